// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file: NUM_REGS word registers with byte strobes, read-only
// status slots, independently buffered AW/W channels and per-register write pulses.
module axi4_lite_slv_reg_file #(
  parameter int unsigned                        ADDR_BIT_WIDTH = 4,
  parameter int unsigned                        DATA_BIT_WIDTH = 32,
  parameter int unsigned                        NUM_REGS       = 4,
  parameter logic [NUM_REGS-1:0]                RO_MASK        = '0,
  parameter logic [NUM_REGS*DATA_BIT_WIDTH-1:0] RST_VALS       = '0
) (
  input  logic                               i_clk,
  input  logic                               i_sync_rst,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_awaddr,
  input  logic [2:0]                         i_awprot,
  input  logic                               i_awvalid,
  output logic                               o_awready,
  input  logic [DATA_BIT_WIDTH-1:0]          i_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]        i_wstrb,
  input  logic                               i_wvalid,
  output logic                               o_wready,
  output logic [1:0]                         o_bresp,
  output logic                               o_bvalid,
  input  logic                               i_bready,
  input  logic [ADDR_BIT_WIDTH-1:0]          i_araddr,
  input  logic [2:0]                         i_arprot,
  input  logic                               i_arvalid,
  output logic                               o_arready,
  output logic [DATA_BIT_WIDTH-1:0]          o_rdata,
  output logic [1:0]                         o_rresp,
  output logic                               o_rvalid,
  input  logic                               i_rready,
  output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]                o_wr_pulse,
  input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] i_ro_vals
);

  localparam int unsigned StrbW      = DATA_BIT_WIDTH / 8;
  localparam int unsigned OffW       = $clog2(StrbW);
  localparam int unsigned IdxW       = ADDR_BIT_WIDTH - OffW;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic                      aw_full_q, aw_full_d;
  logic [IdxW-1:0]           aw_idx_q, aw_idx_d;
  logic                      w_full_q, w_full_d;
  logic [DATA_BIT_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]          w_strb_q, w_strb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      rvalid_q, rvalid_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
  logic [DATA_BIT_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_BIT_WIDTH-1:0] regs_d [NUM_REGS];

  logic            aw_hs, w_hs, ar_hs, commit;
  logic [IdxW-1:0] ar_idx;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_in;
  assign unused_in = ^{i_awprot, i_arprot, i_awaddr[OffW-1:0], i_araddr[OffW-1:0]};

  assign o_awready  = !aw_full_q && !i_sync_rst;
  assign o_wready   = !w_full_q && !i_sync_rst;
  assign o_arready  = !rvalid_q && !i_sync_rst;
  assign o_bvalid   = bvalid_q;
  assign o_bresp    = bresp_q;
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;
  assign o_rresp    = rresp_q;
  assign o_wr_pulse = wr_pulse_q;

  assign aw_hs  = i_awvalid && o_awready;
  assign w_hs   = i_wvalid && o_wready;
  assign ar_hs  = i_arvalid && o_arready;
  assign commit = aw_full_q && w_full_q && !bvalid_q;
  assign ar_idx = i_araddr[ADDR_BIT_WIDTH-1:OffW];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = regs_q[g];
  end

  // Write path: aw_hs and commit are mutually exclusive (aw_full gates both).
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_idx_d   = aw_idx_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = i_awaddr[ADDR_BIT_WIDTH-1:OffW];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = i_wdata;
      w_strb_d = i_wstrb;
    end
    if (bvalid_q && i_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RespSlvErr;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (32'(aw_idx_q) == k && !RO_MASK[k]) begin
          bresp_d       = RespOkay;
          wr_pulse_d[k] = 1'b1;
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (w_strb_q[b]) begin
              regs_d[k][8*b +: 8] = w_data_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read path samples regs_q, so a same-cycle commit is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && i_rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RespSlvErr;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        if (32'(ar_idx) == k) begin
          rresp_d = RespOkay;
          rdata_d = RO_MASK[k] ? i_ro_vals[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] : regs_q[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      wr_pulse_q <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RST_VALS[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      end
    end else begin
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Scoreboard bench for axi4_lite_slv_reg_file: expected B/R responses are queued by the
// stimulus and popped by a monitor on each B/R handshake.
module tb_axi4_lite_slv_reg_file;

  localparam logic [127:0] RstVals = {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
  localparam logic [127:0] RoVals  = {32'hDEAD0003, 32'hCAFEF00D, 32'hDEAD0001, 32'hDEAD0000};
  localparam logic [1:0]   Okay    = 2'b00;
  localparam logic [1:0]   SlvErr  = 2'b10;

  logic         i_clk = 1'b0;
  logic         i_sync_rst = 1'b1;
  logic [4:0]   i_awaddr = '0;
  logic [2:0]   i_awprot = '0;
  logic         i_awvalid = 1'b0;
  logic         o_awready;
  logic [31:0]  i_wdata = '0;
  logic [3:0]   i_wstrb = '0;
  logic         i_wvalid = 1'b0;
  logic         o_wready;
  logic [1:0]   o_bresp;
  logic         o_bvalid;
  logic         i_bready = 1'b1;
  logic [4:0]   i_araddr = '0;
  logic [2:0]   i_arprot = '0;
  logic         i_arvalid = 1'b0;
  logic         o_arready;
  logic [31:0]  o_rdata;
  logic [1:0]   o_rresp;
  logic         o_rvalid;
  logic         i_rready = 1'b1;
  logic [127:0] o_regs;
  logic [3:0]   o_wr_pulse;
  logic [127:0] i_ro_vals = RoVals;

  int          n_vec = 0;
  int          n_err = 0;
  int          pulse_cnt [4] = '{0, 0, 0, 0};
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  always #5 i_clk = ~i_clk;

  axi4_lite_slv_reg_file #(
    .ADDR_BIT_WIDTH(5),
    .DATA_BIT_WIDTH(32),
    .NUM_REGS      (4),
    .RO_MASK       (4'b0100),
    .RST_VALS      (RstVals)
  ) dut (
    .i_clk     (i_clk),
    .i_sync_rst(i_sync_rst),
    .i_awaddr  (i_awaddr),
    .i_awprot  (i_awprot),
    .i_awvalid (i_awvalid),
    .o_awready (o_awready),
    .i_wdata   (i_wdata),
    .i_wstrb   (i_wstrb),
    .i_wvalid  (i_wvalid),
    .o_wready  (o_wready),
    .o_bresp   (o_bresp),
    .o_bvalid  (o_bvalid),
    .i_bready  (i_bready),
    .i_araddr  (i_araddr),
    .i_arprot  (i_arprot),
    .i_arvalid (i_arvalid),
    .o_arready (o_arready),
    .o_rdata   (o_rdata),
    .o_rresp   (o_rresp),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready),
    .o_regs    (o_regs),
    .o_wr_pulse(o_wr_pulse),
    .i_ro_vals (i_ro_vals)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void tmo(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endfunction

  function automatic void chk_regs(input string nm, input logic [127:0] exp);
    for (int k = 0; k < 4; k++) chk(nm, 64'(o_regs[k*32 +: 32]), 64'(exp[k*32 +: 32]));
  endfunction

  // Monitor: pops the scoreboard on every B/R handshake, tallies write pulses.
  always @(negedge i_clk) begin
    if (!i_sync_rst && o_bvalid && i_bready) begin
      if (bq.size() == 0) tmo("b_unexpected");
      else chk("bresp", 64'(o_bresp), 64'(bq.pop_front()));
    end
    if (!i_sync_rst && o_rvalid && i_rready) begin
      if (rq.size() == 0) tmo("r_unexpected");
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        chk("rdata", 64'(o_rdata), 64'(e[31:0]));
        chk("rresp", 64'(o_rresp), 64'(e[33:32]));
      end
    end
    for (int k = 0; k < 4; k++) if (o_wr_pulse[k]) pulse_cnt[k]++;
  end

  task automatic wait_b();
    for (int n = 0; n < 40; n++) begin
      if (bq.size() == 0) return;
      @(posedge i_clk); #2;
    end
    tmo("b_wait");
    bq.delete();
  endtask

  task automatic wait_r();
    for (int n = 0; n < 40; n++) begin
      if (rq.size() == 0) return;
      @(posedge i_clk); #2;
    end
    tmo("r_wait");
    rq.delete();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp);
    logic aw_go, w_go;
    bq.push_back(resp);
    i_awaddr = a; i_awvalid = 1'b1;
    i_wdata = d; i_wstrb = s; i_wvalid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      aw_go = i_awvalid && o_awready;
      w_go  = i_wvalid && o_wready;
      @(posedge i_clk); #1;
      if (aw_go) i_awvalid = 1'b0;
      if (w_go) i_wvalid = 1'b0;
      if (!i_awvalid && !i_wvalid) begin
        wait_b();
        return;
      end
    end
    tmo("wr_handshake");
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    bq.delete();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp);
    rq.push_back({resp, d});
    i_araddr = a; i_arvalid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      if (o_arready) begin
        @(posedge i_clk); #1;
        i_arvalid = 1'b0;
        wait_r();
        return;
      end
    end
    tmo("rd_handshake");
    i_arvalid = 1'b0;
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state and reset value of reg1
    @(negedge i_clk);
    chk("rst_awready", 64'(o_awready), 64'd0);
    chk("rst_wready", 64'(o_wready), 64'd0);
    chk("rst_arready", 64'(o_arready), 64'd0);
    @(posedge i_clk); #1 i_sync_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("rst_rvalid", 64'(o_rvalid), 64'd0);
    chk("rst_pulse", 64'(o_wr_pulse), 64'd0);
    chk_regs("rst_regs", RstVals);
    @(posedge i_clk); #1;
    rd(5'h04, 32'hA5A5A5A5, Okay);

    // 2: full-word then single-byte write; zero-strobe write still pulses
    wr(5'h00, 32'h12345678, 4'hF, Okay);
    wr(5'h00, 32'hFFFFFFFF, 4'b0010, Okay);
    rd(5'h00, 32'h1234FF78, Okay);
    chk("pulse0_twice", 64'(pulse_cnt[0]), 64'd2);
    wr(5'h0C, 32'h11111111, 4'h0, Okay);
    chk("pulse3_zero_strb", 64'(pulse_cnt[3]), 64'd1);
    chk_regs("regs_step2", {32'h0, 32'h0, 32'hA5A5A5A5, 32'h1234FF78});

    // 3: W leads AW by two cycles, B held with bready low
    i_bready = 1'b0;
    bq.push_back(Okay);
    i_wdata = 32'hA0B0C0D0; i_wstrb = 4'hF; i_wvalid = 1'b1;
    @(negedge i_clk); chk("w_early_ready", 64'(o_wready), 64'd1);
    @(posedge i_clk); #1 i_wvalid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_awaddr = 5'h0C; i_awvalid = 1'b1;
    @(negedge i_clk); chk("aw_late_ready", 64'(o_awready), 64'd1);
    @(posedge i_clk); #1 i_awvalid = 1'b0;
    @(posedge i_clk); #1;
    bq.push_back(Okay);
    i_awaddr = 5'h00; i_awvalid = 1'b1;
    i_wdata = 32'h00000055; i_wstrb = 4'hF; i_wvalid = 1'b1;
    @(negedge i_clk);
    chk("hold1_bvalid", 64'(o_bvalid), 64'd1);
    chk("hold1_bresp", 64'(o_bresp), 64'(Okay));
    chk("hold1_pulse", 64'(o_wr_pulse), 64'h8);
    @(posedge i_clk); #1 i_awvalid = 1'b0; i_wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      chk("hold_bvalid", 64'(o_bvalid), 64'd1);
      chk("hold_bresp", 64'(o_bresp), 64'(Okay));
      chk("hold_awready", 64'(o_awready), 64'd0);
      chk("hold_no_commit", 64'(o_wr_pulse), 64'd0);
      @(posedge i_clk); #1;
    end
    i_bready = 1'b1;
    wait_b();
    rd(5'h0C, 32'hA0B0C0D0, Okay);
    rd(5'h00, 32'h00000055, Okay);

    // 4: out-of-range and read-only writes are rejected
    wr(5'h10, 32'hBAD0BAD0, 4'hF, SlvErr);
    wr(5'h08, 32'hBAD1BAD1, 4'hF, SlvErr);
    chk_regs("regs_after_err", {32'hA0B0C0D0, 32'h0, 32'hA5A5A5A5, 32'h00000055});
    rd(5'h08, 32'hCAFEF00D, Okay);

    // 5: R held with rready low; RO value captured at the AR handshake
    i_rready = 1'b0;
    rq.push_back({Okay, 32'hCAFEF00D});
    i_araddr = 5'h08; i_arvalid = 1'b1;
    @(posedge i_clk); #1 i_arvalid = 1'b0;
    i_ro_vals[95:64] = 32'h12121212;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      chk("rhold_rvalid", 64'(o_rvalid), 64'd1);
      chk("rhold_rdata", 64'(o_rdata), 64'hCAFEF00D);
      chk("rhold_arready", 64'(o_arready), 64'd0);
      @(posedge i_clk); #1;
    end
    i_rready = 1'b1;
    wait_r();
    i_ro_vals = RoVals;
    rd(5'h14, 32'h0, SlvErr);

    // 6: reset with a buffered AW and a pending R, then a fresh write
    i_awaddr = 5'h00; i_awvalid = 1'b1;
    @(posedge i_clk); #1 i_awvalid = 1'b0;
    i_rready = 1'b0;
    i_araddr = 5'h04; i_arvalid = 1'b1;
    @(posedge i_clk); #1 i_arvalid = 1'b0;
    @(negedge i_clk);
    chk("pre_rst_awready", 64'(o_awready), 64'd0);
    chk("pre_rst_rvalid", 64'(o_rvalid), 64'd1);
    @(posedge i_clk); #1 i_sync_rst = 1'b1;
    @(negedge i_clk);
    chk("in_rst_arready", 64'(o_arready), 64'd0);
    chk("in_rst_wready", 64'(o_wready), 64'd0);
    @(posedge i_clk); #1 i_sync_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_rvalid", 64'(o_rvalid), 64'd0);
    chk("post_rst_bvalid", 64'(o_bvalid), 64'd0);
    chk("post_rst_awready", 64'(o_awready), 64'd1);
    chk("post_rst_arready", 64'(o_arready), 64'd1);
    chk_regs("post_rst_regs", RstVals);
    @(posedge i_clk); #1;
    i_rready = 1'b1;
    wr(5'h04, 32'h0F0F0F0F, 4'hF, Okay);
    rd(5'h04, 32'h0F0F0F0F, Okay);
    rd(5'h00, 32'h00000000, Okay);

    @(posedge i_clk); #1;
    chk("pulse_total0", 64'(pulse_cnt[0]), 64'd3);
    chk("pulse_total1", 64'(pulse_cnt[1]), 64'd1);
    chk("pulse_total2", 64'(pulse_cnt[2]), 64'd0);
    chk("pulse_total3", 64'(pulse_cnt[3]), 64'd2);
    chk("bq_drained", 64'(bq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
